// File: rtl/uart_word_sender.sv
// uart_word_sender: buffers 32-bit words (or 16-bit compact halves) in a
// small FIFO and serializes them MSB-byte-first on a UART 8N1 line.
module uart_word_sender #(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int BAUD_RATE    = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [31:0]                   tx_data,
    input  logic                          tx_half,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx_serial,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [32:0]     r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;

    logic [31:0]     r_word;
    logic [2:0]      r_bytes_left;
    logic [7:0]      r_shift;
    logic [2:0]      r_bit_idx;
    logic [CW-1:0]   r_baud;

    logic            w_push;
    logic            w_pop;
    logic            w_fifo_nempty;
    logic            w_baud_done;
    logic            w_last_byte;
    logic [32:0]     w_head;
    logic            w_tx;

    assign w_fifo_nempty = (r_count != '0);
    assign w_baud_done   = (r_baud == BAUD_LAST);
    assign w_last_byte   = (r_bytes_left <= 3'd1);
    assign w_head        = r_mem[r_rd_ptr];

    assign tx_ready   = (r_count != FULL_CNT);
    assign w_push     = tx_valid && tx_ready;

    // Pop from IDLE, or straight out of the final STOP so queued words
    // keep the same one-cycle LOAD gap as bytes inside a word.
    assign w_pop = w_fifo_nempty &&
                   ((r_state == S_IDLE) ||
                    (r_state == S_STOP && w_baud_done && w_last_byte));

    assign fifo_count = r_count;
    assign busy       = w_fifo_nempty || (r_state != S_IDLE);
    assign tx_serial  = w_tx;

    // FIFO storage; contents need no reset since the pointers are cleared.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {tx_half, tx_data};
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop cancel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_fifo_nempty) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_next = S_START;
            end
            S_START: begin
                if (w_baud_done) begin
                    w_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_baud_done && r_bit_idx == 3'd7) begin
                    w_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_baud_done) begin
                    if (!w_last_byte || w_fifo_nempty) begin
                        w_next = S_LOAD;
                    end else begin
                        w_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // FSM output: line level for the current state.
    always_comb begin
        w_tx = 1'b1;
        case (r_state)
            S_START: w_tx = 1'b0;
            S_DATA:  w_tx = r_shift[r_bit_idx];
            default: w_tx = 1'b1;
        endcase
    end

    // Baud, bit, byte counters and the word/bit shifters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_baud       <= '0;
            r_word       <= '0;
            r_bytes_left <= '0;
            r_shift      <= '0;
            r_bit_idx    <= '0;
        end else begin
            if (r_state != w_next || w_baud_done) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + CW'(1);
            end

            if (w_pop) begin
                if (w_head[32]) begin
                    r_word       <= {w_head[15:0], 16'h0000};
                    r_bytes_left <= 3'd2;
                end else begin
                    r_word       <= w_head[31:0];
                    r_bytes_left <= 3'd4;
                end
            end else if (r_state == S_STOP && w_baud_done) begin
                r_bytes_left <= r_bytes_left - 3'd1;
                if (!w_last_byte) begin
                    r_word <= {r_word[23:0], 8'h00};
                end
            end

            if (r_state == S_LOAD) begin
                r_shift <= r_word[31:24];
            end

            if (r_state == S_START) begin
                r_bit_idx <= 3'd0;
            end else if (r_state == S_DATA && w_baud_done &&
                         r_bit_idx != 3'd7) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_word_sender.sv
// Bench for uart_word_sender: expected bytes are queued at push time and a
// line decoder pops and compares each received byte.
module tb_uart_word_sender;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
    localparam int BYTE_T = 10 * CPB + 1;
    localparam int LIM   = 8 * 4 * BYTE_T + 200;

    typedef struct {
        logic [7:0] b;
        bit         contig;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] tx_data;
    logic        tx_half;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_serial;
    logic        busy;
    logic [2:0]  fifo_count;

    exp_t q[$];
    int   n_vec;
    int   n_err;
    int   cyc;
    int   rst_ev;
    int   last_start;
    int   stalled;

    uart_word_sender #(
        .CLK_FREQ  (1_843_200),
        .BAUD_RATE (115200),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_data   (tx_data),
        .tx_half   (tx_half),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_serial (tx_serial),
        .busy      (busy),
        .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial rst_ev = 0;
    always @(negedge rst) rst_ev = rst_ev + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    task automatic add_byte(input logic [7:0] b, input bit c);
        exp_t e;
        e.b = b;
        e.contig = c;
        q.push_back(e);
    endtask

    task automatic push_word(input logic [31:0] d, input logic h,
                             input bit contig0);
        int t;
        t = 0;
        @(negedge clk);
        tx_data  = d;
        tx_half  = h;
        tx_valid = 1'b1;
        while (!tx_ready && t < LIM) begin
            if (t == 0) begin
                stalled++;
                chk("ready_low_only_when_full", 32'(fifo_count), DEPTH);
            end
            @(negedge clk);
            t++;
        end
        if (!tx_ready) begin
            chk("push_timeout", 32'(tx_ready), 1);
        end
        if (h) begin
            add_byte(d[15:8], contig0);
            add_byte(d[7:0], 1'b1);
        end else begin
            add_byte(d[31:24], contig0);
            add_byte(d[23:16], 1'b1);
            add_byte(d[15:8], 1'b1);
            add_byte(d[7:0], 1'b1);
        end
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < LIM) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (busy) begin
            chk("idle_timeout", 32'(busy), 0);
        end
    endtask

    // Line decoder: samples mid-bit and scores each byte against the queue.
    initial begin : mon
        int         t0;
        int         ev0;
        logic [7:0] b;
        logic       sb;
        logic       st;
        exp_t       e;
        last_start = 0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && tx_serial === 1'b0) begin
                t0  = cyc;
                ev0 = rst_ev;
                repeat (CPB / 2) @(negedge clk);
                sb = tx_serial;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx_serial;
                end
                repeat (CPB) @(negedge clk);
                st = tx_serial;
                if (ev0 == rst_ev) begin
                    chk("start_bit", 32'(sb), 0);
                    chk("stop_bit", 32'(st), 1);
                    if (q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_byte: got %h expected none", b);
                    end else begin
                        e = q.pop_front();
                        chk("byte_value", 32'(b), 32'(e.b));
                        if (e.contig) begin
                            chk("start_to_start", t0 - last_start, BYTE_T);
                        end
                    end
                    last_start = t0;
                end
            end
        end
    end

    initial begin : stim
        int n;
        n_vec    = 0;
        n_err    = 0;
        stalled  = 0;
        rst      = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        tx_half  = 1'b0;
        #12;
        chk("rst_serial", 32'(tx_serial), 1);
        chk("rst_ready", 32'(tx_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_count", 32'(fifo_count), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // single full word, latency and duration
        push_word(32'h0000_0013, 1'b0, 1'b0);
        chk("count_after_push", 32'(fifo_count), 1);
        chk("busy_after_push", 32'(busy), 1);
        @(posedge clk);
        #1;
        chk("count_after_pop", 32'(fifo_count), 0);
        chk("line_high_in_load", 32'(tx_serial), 1);
        @(posedge clk);
        #1;
        chk("start_bit_at_n2", 32'(tx_serial), 0);
        n = 1;
        while (busy && n < LIM) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("pop_to_idle_cycles", n, 4 * BYTE_T);
        chk("line_idle_after_word", 32'(tx_serial), 1);
        chk("queue_empty_word", q.size(), 0);

        // compact half word
        repeat (5) @(negedge clk);
        push_word(32'hDEAD_F00F, 1'b1, 1'b0);
        wait_idle();
        repeat (3) @(negedge clk);
        chk("line_idle_after_half", 32'(tx_serial), 1);
        chk("queue_empty_half", q.size(), 0);

        // back-to-back words
        push_word(32'hAAAA_AAAA, 1'b0, 1'b0);
        push_word(32'hCCCC_CCCC, 1'b0, 1'b1);
        push_word(32'hFFFF_FFFF, 1'b0, 1'b1);
        wait_idle();
        chk("queue_empty_b2b", q.size(), 0);

        // backpressure with six distinct words
        repeat (5) @(negedge clk);
        push_word(32'h0102_0304, 1'b0, 1'b0);
        push_word(32'h1112_1314, 1'b0, 1'b1);
        push_word(32'h2122_2324, 1'b0, 1'b1);
        push_word(32'h3132_3334, 1'b0, 1'b1);
        push_word(32'h4142_4344, 1'b0, 1'b1);
        push_word(32'h5152_5354, 1'b0, 1'b1);
        chk("stall_seen", 32'(stalled > 0), 1);
        wait_idle();
        chk("queue_empty_bp", q.size(), 0);

        // reset during bit 3 of byte 2
        repeat (5) @(negedge clk);
        push_word(32'hA5C3_0F96, 1'b0, 1'b0);
        push_word(32'h1122_3344, 1'b0, 1'b1);
        repeat (2 + BYTE_T + 4 * CPB + CPB / 2 - 1) @(posedge clk);
        #2;
        chk("count_before_rst", 32'(fifo_count), 1);
        chk("line_in_data_bit3", 32'(tx_serial), 1'b0);
        rst = 1'b0;
        q.delete();
        #1;
        chk("rst_mid_serial", 32'(tx_serial), 1);
        chk("rst_mid_count", 32'(fifo_count), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_ready", 32'(tx_ready), 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        chk("no_resume_after_rst", 32'(busy), 0);
        push_word(32'h1234_5678, 1'b0, 1'b0);
        wait_idle();
        repeat (4 * CPB) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        chk("final_line_idle", 32'(tx_serial), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
